pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central sequencer for the four synchronous pipeline-stage registers (PS1 IF/ID .. PS4 MEM/WB).
//  Drives per-stage en/clear and the PC write enable from hazard inputs: load-use stall,
//  branch/jump mispredict flush, data-memory busy freeze, and syscall halt/resume.
//  Sits beside the datapath; every stage register's en/clear inputs come only from this block.
// PARAMETERS
//  CNT_W        32   width of performance counters (PERF_CNT_EN only)
// PORTS
//  clk           in   1      clock, all state on rising edge
//  rst_n         in   1      reset, asynchronous, active-low
//  load_use      in   1      ID reads a reg that the load currently in EX writes
//  mispredict    in   1      EX resolved branch/jump != pc_guessed
//  mem_busy      in   1      data memory not ready this cycle
//  syscall_halt  in   1      halting syscall present at PS4 output
//  resume        in   1      external continue request (level; rising edge used)
//  pc_en         out  1      PC register write enable
//  stage_en      out  4      bit i = enable of PS(i+1)
//  stage_clear   out  4      bit i = synchronous clear of PS(i+1); clear beats en in the register
//  halted        out  1      1 while in HALT
//  ctrl_state    out  2      current FSM state (BOOT=0, RUN=1, HALT=2, RESUME=3)
//  stall_cnt     out  CNT_W  cycles with pc_en=0 in RUN (PERF_CNT_EN)
//  flush_cnt     out  CNT_W  accepted mispredict flushes (PERF_CNT_EN)
//  halt_cnt      out  CNT_W  cycles spent in HALT (PERF_CNT_EN)
// BEHAVIOUR
//  - Registered: ctrl_state, resume_q, counters. All other outputs combinational from state+inputs.
//  - Reset: ctrl_state=BOOT, resume_q=0, counters=0. While in reset/BOOT: pc_en=0, stage_en=0,
//    stage_clear=4'b1111, halted=0. BOOT -> RUN unconditionally next cycle (1-cycle flush).
//  - RUN decode, priority highest first, exactly one row applies per cycle:
//    1 mem_busy:     pc_en=0, stage_en=0000, stage_clear=0000 (full freeze; hazards held, not lost)
//    2 syscall_halt: pc_en=0, stage_en=0000, clear=0000; next state HALT
//    3 mispredict:   pc_en=1, stage_en=1111, stage_clear=0011 (kill wrong-path PS1/PS2)
//    4 load_use:     pc_en=0, stage_en=1110, stage_clear=0010 (hold PS1, bubble into PS2)
//    5 none:         pc_en=1, stage_en=1111, stage_clear=0000
//  - mispredict+load_use same cycle: mispredict wins; load_use ignored (instruction is wrong path).
//  - mispredict/load_use under mem_busy: frozen; acted on in first cycle mem_busy=0 if still asserted.
//  - HALT: pc_en=0, stage_en=0000, clear=0000, halted=1. resume_q<=resume every cycle in all states.
//    resume & !resume_q -> RESUME. resume held high on HALT entry does not resume; needs 0->1.
//  - RESUME (1 cycle): decode as RUN rows 1,3,4,5 with syscall_halt ignored, so the syscall
//    leaves PS4 without retriggering; if mem_busy, stay in RESUME. Then -> RUN.
//  - rst_n low in any state: immediate return to BOOT outputs; pending halt/resume discarded.
//  - Unused 2-bit encodings: none reachable; default branch -> BOOT.
// CONFIGURATION
//  - `PERF_CNT_EN defined: stall_cnt +1 when state==RUN && pc_en==0 (rows 1,2,4); flush_cnt +1
//    when row 3 taken (RUN or RESUME); halt_cnt +1 each HALT cycle. All saturate at 2^CNT_W-1.
//  - Undefined: counter registers not built; stall_cnt/flush_cnt/halt_cnt ports remain, tied 0.
// TESTING
//  - Reset release, no hazards: cycle0 clear=1111,pc_en=0; cycle1+ en=1111,clear=0000,pc_en=1.
//  - load_use=1 for 1 cycle in RUN -> en=1110,clear=0010,pc_en=0; next cycle back to en=1111.
//  - mispredict=1 & load_use=1 together -> clear=0011,pc_en=1; flush_cnt 0->1 (PERF_CNT_EN).
//  - mem_busy=1 for 3 cycles with mispredict=1 -> 3 freeze cycles, then clear=0011; stall_cnt=3.
//  - syscall_halt=1 -> HALT, halted=1; resume held 1 before entry stays HALT; 0->1 -> RESUME with
//    syscall_halt=1 still applied -> en=1111 once, then RUN; halt_cnt equals HALT cycles.
//  - rst_n pulsed low mid-HALT -> ctrl_state=BOOT asynchronously, clear=1111, halted=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the four pipeline-stage registers and the PC write enable.
// Optional performance counters are built when PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use,
  input  logic             mispredict,
  input  logic             mem_busy,
  input  logic             syscall_halt,
  input  logic             resume,
  output logic             pc_en,
  output logic [3:0]       stage_en,
  output logic [3:0]       stage_clear,
  output logic             halted,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] halt_cnt
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALT   = 2'd2,
    RESUME = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   r_resume_q;
  logic   w_flush_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BOOT;
      r_resume_q <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_resume_q <= resume;
    end
  end

  // RESUME decodes like RUN but ignores syscall_halt so the halting
  // instruction can drain out of PS4 without re-entering HALT.
  always_comb begin
    w_state_next  = BOOT;
    pc_en         = 1'b0;
    stage_en      = 4'b0000;
    stage_clear   = 4'b1111;
    halted        = 1'b0;
    w_flush_taken = 1'b0;
    case (r_state)
      BOOT: begin
        w_state_next = RUN;
      end
      RUN, RESUME: begin
        stage_clear  = 4'b0000;
        w_state_next = RUN;
        if (mem_busy) begin
          if (r_state == RESUME) w_state_next = RESUME;
        end else if (syscall_halt && (r_state == RUN)) begin
          w_state_next = HALT;
        end else if (mispredict) begin
          pc_en         = 1'b1;
          stage_en      = 4'b1111;
          stage_clear   = 4'b0011;
          w_flush_taken = 1'b1;
        end else if (load_use) begin
          stage_en    = 4'b1110;
          stage_clear = 4'b0010;
        end else begin
          pc_en    = 1'b1;
          stage_en = 4'b1111;
        end
      end
      HALT: begin
        stage_clear  = 4'b0000;
        halted       = 1'b1;
        w_state_next = (resume && !r_resume_q) ? RESUME : HALT;
      end
      default: begin
        w_state_next = BOOT;
      end
    endcase
  end

  assign ctrl_state = r_state;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_halt_cnt;

  // All counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_halt_cnt  <= '0;
    end else begin
      if ((r_state == RUN) && !pc_en && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_taken && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if ((r_state == HALT) && (r_halt_cnt != '1))
        r_halt_cnt <= r_halt_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign halt_cnt  = r_halt_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign halt_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; inputs change just after
// the falling edge and outputs are sampled 1 time unit later.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 32;
`ifdef PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_use = 1'b0;
  logic             mispredict = 1'b0;
  logic             mem_busy = 1'b0;
  logic             syscall_halt = 1'b0;
  logic             resume = 1'b0;
  logic             pc_en;
  logic [3:0]       stage_en;
  logic [3:0]       stage_clear;
  logic             halted;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] halt_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_use     (load_use),
    .mispredict   (mispredict),
    .mem_busy     (mem_busy),
    .syscall_halt (syscall_halt),
    .resume       (resume),
    .pc_en        (pc_en),
    .stage_en     (stage_en),
    .stage_clear  (stage_clear),
    .halted       (halted),
    .ctrl_state   (ctrl_state),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .halt_cnt     (halt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the combinational control bundle plus state in one transaction line.
  task automatic chk_ctrl(input string tag, input logic [1:0] st, input logic pc,
                          input logic [3:0] en, input logic [3:0] clr, input logic h);
    $display("t=%0t %s: state=%0d pc_en=%0b en=%b clr=%b halted=%0b", $time, tag,
             ctrl_state, pc_en, stage_en, stage_clear, halted);
    chk({tag, ".state"}, 32'(ctrl_state), 32'(st));
    chk({tag, ".pc_en"}, 32'(pc_en), 32'(pc));
    chk({tag, ".en"}, 32'(stage_en), 32'(en));
    chk({tag, ".clr"}, 32'(stage_clear), 32'(clr));
    chk({tag, ".halted"}, 32'(halted), 32'(h));
  endtask

  task automatic chk_cnt(input string tag, input int s, input int f, input int h);
    chk({tag, ".stall_cnt"}, stall_cnt, 32'(s * PERF));
    chk({tag, ".flush_cnt"}, flush_cnt, 32'(f * PERF));
    chk({tag, ".halt_cnt"}, halt_cnt, 32'(h * PERF));
  endtask

  initial begin
    // Held in reset
    repeat (2) @(negedge clk);
    #1;
    chk_ctrl("reset", 2'd0, 1'b0, 4'b0000, 4'b1111, 1'b0);
    chk_cnt("reset", 0, 0, 0);

    // Release: first cycle is the BOOT flush
    @(negedge clk); rst_n = 1'b1; #1;
    chk_ctrl("boot", 2'd0, 1'b0, 4'b0000, 4'b1111, 1'b0);
    @(negedge clk); #1;
    chk_ctrl("run_idle", 2'd1, 1'b1, 4'b1111, 4'b0000, 1'b0);

    // Load-use stall for one cycle
    @(negedge clk); load_use = 1'b1; #1;
    chk_ctrl("load_use", 2'd1, 1'b0, 4'b1110, 4'b0010, 1'b0);
    @(negedge clk); load_use = 1'b0; #1;
    chk_ctrl("after_lu", 2'd1, 1'b1, 4'b1111, 4'b0000, 1'b0);
    chk_cnt("after_lu", 1, 0, 0);

    // Mispredict beats load_use
    @(negedge clk); mispredict = 1'b1; load_use = 1'b1; #1;
    chk_ctrl("mp_lu", 2'd1, 1'b1, 4'b1111, 4'b0011, 1'b0);
    @(negedge clk); mispredict = 1'b0; load_use = 1'b0; #1;
    chk_cnt("after_mp", 1, 1, 0);

    // Three frozen cycles hold a pending mispredict
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_busy = 1'b1; mispredict = 1'b1; #1;
      chk_ctrl($sformatf("busy%0d", i), 2'd1, 1'b0, 4'b0000, 4'b0000, 1'b0);
    end
    @(negedge clk); mem_busy = 1'b0; #1;
    chk_ctrl("busy_release", 2'd1, 1'b1, 4'b1111, 4'b0011, 1'b0);
    chk_cnt("busy_release", 4, 1, 0);
    @(negedge clk); mispredict = 1'b0; #1;
    chk_cnt("after_busy", 4, 2, 0);

    // Syscall halt with resume already high: must not resume until 0->1
    @(negedge clk); resume = 1'b1; syscall_halt = 1'b1; #1;
    chk_ctrl("halt_req", 2'd1, 1'b0, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk); #1;
    chk_ctrl("halt1", 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b1);
    @(negedge clk); #1;
    chk_ctrl("halt2_res_held", 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b1);
    @(negedge clk); resume = 1'b0; #1;
    chk_ctrl("halt3_res_low", 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b1);
    @(negedge clk); resume = 1'b1; #1;
    chk_ctrl("halt4_res_rise", 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b1);
    @(negedge clk); #1;
    chk_ctrl("resume", 2'd3, 1'b1, 4'b1111, 4'b0000, 1'b0);
    chk_cnt("resume", 5, 2, 4);
    @(negedge clk); syscall_halt = 1'b0; resume = 1'b0; #1;
    chk_ctrl("post_resume", 2'd1, 1'b1, 4'b1111, 4'b0000, 1'b0);

    // mem_busy outranks syscall_halt: no HALT entry
    @(negedge clk); mem_busy = 1'b1; syscall_halt = 1'b1; #1;
    chk_ctrl("busy_sys", 2'd1, 1'b0, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk); mem_busy = 1'b0; syscall_halt = 1'b0; #1;
    chk_ctrl("busy_sys_next", 2'd1, 1'b1, 4'b1111, 4'b0000, 1'b0);
    chk_cnt("busy_sys_next", 6, 2, 4);

    // Asynchronous reset in the middle of HALT
    @(negedge clk); syscall_halt = 1'b1; #1;
    @(negedge clk); syscall_halt = 1'b0; #1;
    chk_ctrl("halt_again", 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b1);
    #2; rst_n = 1'b0; #1;
    chk_ctrl("async_rst", 2'd0, 1'b0, 4'b0000, 4'b1111, 1'b0);
    chk_cnt("async_rst", 0, 0, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    @(negedge clk); #1;
    chk_ctrl("rerun", 2'd1, 1'b1, 4'b1111, 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
